mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mdu_pkg.sv | 12 +
 rtl/mul_div_unit_if.sv | 14 +
 rtl/mdu_div_step.sv | 16 +
 rtl/mul_div_unit.sv | 138 +++++++++++++
 tb/tb_mul_div_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mdu_pkg;
  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11} mdu_op_e;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FIN = 2'b10} mdu_state_e;

  // Magnitude of v when sgn is set and v is negative, else v unchanged.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface mul_div_unit_if;
  import mdu_pkg::*;
  logic        start;
  mdu_op_e     op;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  modport master (output start, op, a, b, hi_we, lo_we, wdata, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, hi_we, lo_we, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module mdu_div_step (
  input  logic [31:0] i_rem,
  input  logic [31:0] i_quo,
  input  logic [31:0] i_dvs,
  output logic [31:0] o_rem,
  output logic [31:0] o_quo
);
  logic [32:0] w_shift, w_diff;

  assign w_shift = {i_rem, i_quo[31]};
  assign w_diff  = w_shift - {1'b0, i_dvs};
  // Bit 32 of the difference is the borrow: restore on borrow, else keep the difference.
  assign o_rem   = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
  assign o_quo   = {i_quo[30:0], ~w_diff[32]};
endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO path.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU complete at once with no effect.
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  mul_div_unit_if.slave bus
);
  mdu_state_e  r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic [31:0] r_b, r_ph, r_pl, r_hi, r_lo;
  logic        r_neg_q;
  logic        w_accept, w_sgn, w_last;
  logic [31:0] w_abs_a, w_abs_b, w_ph_n, w_pl_n, w_res_hi, w_res_lo;
  logic [32:0] w_madd;
  logic [63:0] w_prod;
`ifdef MDU_DIV_EN
  logic        r_is_div, r_dz, r_neg_r;
  logic [31:0] r_a, w_rem, w_quo;
`endif

  assign w_accept = bus.start && (r_state != RUN);
  assign w_sgn    = ~bus.op[0];
  assign w_last   = (r_cnt == 5'(MDU_ITER - 1));
  assign w_abs_a  = abs32(bus.a, w_sgn);
  assign w_abs_b  = abs32(bus.b, w_sgn);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

  always_comb begin
    w_state_nxt = r_state;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (r_state)
      IDLE, FIN: begin
        bus.done    = (r_state == FIN);
        w_state_nxt = IDLE;
        if (bus.start) begin
`ifdef MDU_DIV_EN
          w_state_nxt = RUN;
`else
          w_state_nxt = bus.op[1] ? FIN : RUN;
`endif
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (w_last) w_state_nxt = FIN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift-add multiply on magnitudes: {r_ph,r_pl} holds partial product and remaining multiplier.
  assign w_madd = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_b} : 33'd0);
  assign w_prod = {w_madd[32:1], w_madd[0], r_pl[31:1]};

`ifdef MDU_DIV_EN
  mdu_div_step u_div_step (
    .i_rem (r_ph),
    .i_quo (r_pl),
    .i_dvs (r_b),
    .o_rem (w_rem),
    .o_quo (w_quo)
  );

  always_comb begin
    w_ph_n               = w_prod[63:32];
    w_pl_n               = w_prod[31:0];
    {w_res_hi, w_res_lo} = r_neg_q ? -w_prod : w_prod;
    if (r_is_div) begin
      w_ph_n = w_rem;
      w_pl_n = w_quo;
      if (r_dz) begin
        w_res_hi = r_a;
        w_res_lo = '1;
      end else begin
        w_res_hi = r_neg_r ? -w_rem : w_rem;
        w_res_lo = r_neg_q ? -w_quo : w_quo;
      end
    end
  end
`else
  assign w_ph_n               = w_prod[63:32];
  assign w_pl_n               = w_prod[31:0];
  assign {w_res_hi, w_res_lo} = r_neg_q ? -w_prod : w_prod;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_ph    <= '0;
      r_pl    <= '0;
      r_neg_q <= 1'b0;
`ifdef MDU_DIV_EN
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_neg_r  <= 1'b0;
      r_a      <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        // MTHI/MTLO in the same cycle as an accepted start are dropped.
        r_cnt   <= '0;
        r_ph    <= '0;
        r_neg_q <= w_sgn & (bus.a[31] ^ bus.b[31]);
`ifdef MDU_DIV_EN
        r_is_div <= bus.op[1];
        r_dz     <= (bus.b == '0);
        r_neg_r  <= w_sgn & bus.a[31];
        r_a      <= bus.a;
        r_pl     <= bus.op[1] ? w_abs_a : w_abs_b;
        r_b      <= bus.op[1] ? w_abs_b : w_abs_a;
`else
        r_pl     <= w_abs_b;
        r_b      <= w_abs_a;
`endif
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + 5'd1;
        r_ph  <= w_ph_n;
        r_pl  <= w_pl_n;
        if (w_last) begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
      end else begin
        if (bus.hi_we) r_hi <= bus.wdata;
        if (bus.lo_we) r_lo <= bus.wdata;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; divider cases follow MDU_DIV_EN.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mul_div_unit_if bus ();
  mul_div_unit dut (.clk(clk), .reset(reset), .bus(bus.slave));

  task automatic idle_inputs();
    bus.start = 1'b0; bus.op = MULTU; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
  endtask

  // Starts an op (optionally on the next falling edge) and returns cycles until done and busy count.
  task automatic run_op(input bit wait_edge, input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt);
    if (wait_edge) @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    lat = 0; bcnt = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) bcnt++;
      if (bus.done) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
    tests++; if (bus.hi !== 32'h0) begin fails++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    tests++; if (bus.lo !== 32'h0) begin fails++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    reset = 1'b0;
  endtask

  task automatic test_multu();
    int lat, bcnt;
    run_op(1'b1, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
    tests++; if (lat != 33) begin fails++; $display("FAIL multu_latency got %0d want 33", lat); end
    tests++; if (bcnt != 32) begin fails++; $display("FAIL multu_busy_cycles got %0d want 32", bcnt); end
    tests++; if (bus.hi !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_hi got %h want fffffffe", bus.hi); end
    tests++; if (bus.lo !== 32'h00000001) begin fails++; $display("FAIL multu_lo got %h want 00000001", bus.lo); end
    @(negedge clk);
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL done_single_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_mult_back_to_back();
    int lat, bcnt;
    run_op(1'b1, MULT, 32'hFFFFFFFD, 32'd5, lat, bcnt);
    tests++; if (bus.hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_neg_hi got %h want ffffffff", bus.hi); end
    tests++; if (bus.lo !== 32'hFFFFFFF1) begin fails++; $display("FAIL mult_neg_lo got %h want fffffff1", bus.lo); end
    // Second start issued in the FIN cycle of the first.
    run_op(1'b0, MULTU, 32'h00010000, 32'h00010000, lat, bcnt);
    tests++; if (lat != 33) begin fails++; $display("FAIL b2b_latency got %0d want 33", lat); end
    tests++; if ({bus.hi, bus.lo} !== 64'h00000001_00000000) begin
      fails++; $display("FAIL b2b_result got %h%h want 0000000100000000", bus.hi, bus.lo); end
    run_op(1'b1, MULT, 32'h80000000, 32'h80000000, lat, bcnt);
    tests++; if ({bus.hi, bus.lo} !== 64'h40000000_00000000) begin
      fails++; $display("FAIL mult_minmin got %h%h want 4000000000000000", bus.hi, bus.lo); end
    run_op(1'b1, MULT, 32'd7, 32'hFFFFFFFF, lat, bcnt);
    tests++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFF9) begin
      fails++; $display("FAIL mult_7_m1 got %h%h want fffffffffffffff9", bus.hi, bus.lo); end
    run_op(1'b1, MULTU, 32'h80000000, 32'd2, lat, bcnt);
    tests++; if ({bus.hi, bus.lo} !== 64'h00000001_00000000) begin
      fails++; $display("FAIL multu_big got %h%h want 0000000100000000", bus.hi, bus.lo); end
    run_op(1'b1, MULT, 32'h80000000, 32'd2, lat, bcnt);
    tests++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_00000000) begin
      fails++; $display("FAIL mult_big got %h%h want ffffffff00000000", bus.hi, bus.lo); end
  endtask

  // HI=ffffffff, LO=0 on entry (left by the previous task).
  task automatic test_ignore_start();
    int lat = 0, bcnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MULTU; bus.a = 32'd6; bus.b = 32'd7;
    bus.lo_we = 1'b1; bus.wdata = 32'h55555555;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      if (n == 1) begin
        tests++; if (bus.lo !== 32'h0) begin fails++; $display("FAIL mtlo_with_start got %h want 00000000", bus.lo); end
      end
      if (n == 7) begin
        tests++; if (bus.hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mthi_while_busy got %h want ffffffff", bus.hi); end
      end
      if (bus.busy) bcnt++;
      if (bus.done) begin lat = n; break; end
      if (n == 5) begin
        bus.start = 1'b1; bus.op = MULT; bus.a = 32'h0000FFFF; bus.b = 32'h0000FFFF;
        bus.hi_we = 1'b1; bus.wdata = 32'hDEADBEEF;
      end
    end
    tests++; if (lat != 33 || bcnt != 32) begin
      fails++; $display("FAIL ignore_start_timing got lat=%0d busy=%0d want 33/32", lat, bcnt); end
    tests++; if ({bus.hi, bus.lo} !== 64'h00000000_0000002A) begin
      fails++; $display("FAIL ignore_start_result got %h%h want 000000000000002a", bus.hi, bus.lo); end
  endtask

  task automatic test_reset_midrun();
    int dones = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MULTU; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrun_reset_busy got %b want 0", bus.busy); end
    tests++; if ({bus.hi, bus.lo} !== 64'h0) begin
      fails++; $display("FAIL midrun_reset_hilo got %h%h want 0", bus.hi, bus.lo); end
    for (int n = 0; n < 40; n++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    tests++; if (dones != 0) begin fails++; $display("FAIL midrun_no_done got %0d pulses want 0", dones); end
  endtask

  task automatic test_mtlo_mthi();
    @(negedge clk);
    bus.lo_we = 1'b1; bus.wdata = 32'h12345678;
    @(negedge clk);
    bus.lo_we = 1'b0;
    tests++; if (bus.lo !== 32'h12345678) begin fails++; $display("FAIL mtlo got %h want 12345678", bus.lo); end
    tests++; if (bus.hi !== 32'h0) begin fails++; $display("FAIL mtlo_hi_untouched got %h want 0", bus.hi); end
    bus.hi_we = 1'b1; bus.wdata = 32'h11111111;
    @(negedge clk);
    bus.hi_we = 1'b0;
    tests++; if (bus.hi !== 32'h11111111) begin fails++; $display("FAIL mthi got %h want 11111111", bus.hi); end
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div();
    int lat, bcnt;
    run_op(1'b1, DIV, 32'hFFFFFFF9, 32'd2, lat, bcnt);
    tests++; if (lat != 33) begin fails++; $display("FAIL div_latency got %0d want 33", lat); end
    tests++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
      fails++; $display("FAIL div_m7_2 got %h%h want fffffffffffffffd", bus.hi, bus.lo); end
    run_op(1'b1, DIVU, 32'd100, 32'd0, lat, bcnt);
    tests++; if (lat != 33 || {bus.hi, bus.lo} !== 64'h00000064_FFFFFFFF) begin
      fails++; $display("FAIL divu_by_zero got %h%h lat %0d want 00000064ffffffff lat 33", bus.hi, bus.lo, lat); end
    run_op(1'b1, DIV, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
    tests++; if ({bus.hi, bus.lo} !== 64'h00000000_80000000) begin
      fails++; $display("FAIL div_overflow got %h%h want 0000000080000000", bus.hi, bus.lo); end
    run_op(1'b1, DIVU, 32'd100, 32'd7, lat, bcnt);
    tests++; if ({bus.hi, bus.lo} !== 64'h00000002_0000000E) begin
      fails++; $display("FAIL divu_100_7 got %h%h want 000000020000000e", bus.hi, bus.lo); end
    run_op(1'b1, DIV, 32'd7, 32'hFFFFFFFE, lat, bcnt);
    tests++; if ({bus.hi, bus.lo} !== 64'h00000001_FFFFFFFD) begin
      fails++; $display("FAIL div_7_m2 got %h%h want 00000001fffffffd", bus.hi, bus.lo); end
    run_op(1'b1, DIV, 32'hFFFFFFF9, 32'd0, lat, bcnt);
    tests++; if ({bus.hi, bus.lo} !== 64'hFFFFFFF9_FFFFFFFF) begin
      fails++; $display("FAIL div_by_zero got %h%h want fffffff9ffffffff", bus.hi, bus.lo); end
  endtask
`else
  // HI=11111111, LO=12345678 on entry.
  task automatic test_div_disabled();
    int lat, bcnt;
    run_op(1'b1, DIV, 32'd10, 32'd2, lat, bcnt);
    tests++; if (lat != 1 || bcnt != 0) begin
      fails++; $display("FAIL nodiv_timing got lat=%0d busy=%0d want 1/0", lat, bcnt); end
    tests++; if ({bus.hi, bus.lo} !== 64'h11111111_12345678) begin
      fails++; $display("FAIL nodiv_hilo got %h%h want 1111111112345678", bus.hi, bus.lo); end
    run_op(1'b1, DIVU, 32'd100, 32'd0, lat, bcnt);
    tests++; if (lat != 1 || {bus.hi, bus.lo} !== 64'h11111111_12345678) begin
      fails++; $display("FAIL nodiv_divu got %h%h lat %0d want 1111111112345678 lat 1", bus.hi, bus.lo, lat); end
    run_op(1'b1, MULTU, 32'd3, 32'd4, lat, bcnt);
    tests++; if (lat != 33 || {bus.hi, bus.lo} !== 64'h00000000_0000000C) begin
      fails++; $display("FAIL nodiv_multu got %h%h lat %0d want 000000000000000c lat 33", bus.hi, bus.lo, lat); end
  endtask
`endif

  initial begin
    test_reset();
    test_multu();
    test_mult_back_to_back();
    test_ignore_start();
    test_reset_midrun();
    test_mtlo_mthi();
`ifdef MDU_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
